// File: rtl/rpn_lan_rx_pub_acceptor_if.sv
// Bundled stream and BRAM signals for the LAN RX PUB acceptor.
// master = the acceptor, slave = the surrounding node (bridge, app, BRAM).
//
// Handshake semantics, identical on every stream in this bundle: a beat
// transfers on a rising clock edge where tvalid and tready are both high.
// Once tvalid is raised, it and every payload field stay stable until that
// edge. tvalid never waits on tready; tready may depend on tvalid.
interface rpn_lan_rx_pub_acceptor_if #(
   parameter int AXIS_DATA_WIDTH = 512,
   parameter int NODE_ID_WIDTH   = 8,
   parameter int SEQ_W           = 16,
   parameter int BRAM_ADDR_WIDTH = 12,
   parameter int USER_WIDTH      = 8
);
   localparam int KEEP_W = AXIS_DATA_WIDTH / 8;

   // PUB input from the Network Bridge
   logic                       from_nb_LAN_tvalid;
   logic                       from_nb_LAN_tready;
   logic [AXIS_DATA_WIDTH-1:0] from_nb_LAN_tdata;
   logic [KEEP_W-1:0]          from_nb_LAN_tkeep;
   logic [NODE_ID_WIDTH-1:0]   from_nb_LAN_tid;
   logic [NODE_ID_WIDTH-1:0]   from_nb_LAN_tdest;
   logic [USER_WIDTH-1:0]      from_nb_LAN_tuser;
   logic                       from_nb_LAN_tlast;

   // Accepted payload towards the application
   logic                       to_app_tvalid;
   logic                       to_app_tready;
   logic [AXIS_DATA_WIDTH-1:0] to_app_tdata;
   logic [KEEP_W-1:0]          to_app_tkeep;
   logic [NODE_ID_WIDTH-1:0]   to_app_tid;
   logic [NODE_ID_WIDTH-1:0]   to_app_tdest;
   logic                       to_app_tlast;

   // ACK back to the Network Bridge
   logic                       to_nb_ack_tvalid;
   logic                       to_nb_ack_tready;
   logic [AXIS_DATA_WIDTH-1:0] to_nb_ack_tdata;
   logic [NODE_ID_WIDTH-1:0]   to_nb_ack_tdest;
   logic                       to_nb_ack_tlast;

   // Per-sender sequence number BRAM port
   logic                       seq_BRAM_CLK;
   logic                       seq_BRAM_RST;
   logic                       seq_BRAM_EN;
   logic [BRAM_ADDR_WIDTH-1:0] seq_BRAM_ADDR;
   logic [3:0]                 seq_BRAM_WEN;
   logic [SEQ_W-1:0]           seq_BRAM_DIN;
   logic [SEQ_W-1:0]           seq_BRAM_DOUT;

   modport master (
      input  from_nb_LAN_tvalid, from_nb_LAN_tdata, from_nb_LAN_tkeep,
             from_nb_LAN_tid, from_nb_LAN_tdest, from_nb_LAN_tuser, from_nb_LAN_tlast,
      output from_nb_LAN_tready,
      output to_app_tvalid, to_app_tdata, to_app_tkeep, to_app_tid, to_app_tdest, to_app_tlast,
      input  to_app_tready,
      output to_nb_ack_tvalid, to_nb_ack_tdata, to_nb_ack_tdest, to_nb_ack_tlast,
      input  to_nb_ack_tready,
      output seq_BRAM_CLK, seq_BRAM_RST, seq_BRAM_EN, seq_BRAM_ADDR, seq_BRAM_WEN, seq_BRAM_DIN,
      input  seq_BRAM_DOUT
   );

   modport slave (
      output from_nb_LAN_tvalid, from_nb_LAN_tdata, from_nb_LAN_tkeep,
             from_nb_LAN_tid, from_nb_LAN_tdest, from_nb_LAN_tuser, from_nb_LAN_tlast,
      input  from_nb_LAN_tready,
      input  to_app_tvalid, to_app_tdata, to_app_tkeep, to_app_tid, to_app_tdest, to_app_tlast,
      output to_app_tready,
      input  to_nb_ack_tvalid, to_nb_ack_tdata, to_nb_ack_tdest, to_nb_ack_tlast,
      output to_nb_ack_tready,
      input  seq_BRAM_CLK, seq_BRAM_RST, seq_BRAM_EN, seq_BRAM_ADDR, seq_BRAM_WEN, seq_BRAM_DIN,
      output seq_BRAM_DOUT
   );
endinterface

// File: rtl/rpn_lan_rx_pub_acceptor.sv
// Receive side of reliable LAN PUB delivery.
// Looks up the sender's last accepted sequence number in BRAM, delivers
// in-order PUBs to the application then ACKs them, re-ACKs duplicates and
// silently drops PUBs that are ahead of the window. One packet in flight.
// Optional: define RPN_LAN_RX_DROP_STATS_EN to add saturating duplicate and
// drop counters (o_dup_count, o_drop_count).
module rpn_lan_rx_pub_acceptor #(
   parameter int         AXIS_DATA_WIDTH = 512,
   parameter int         NODE_ID_WIDTH   = 8,
   parameter int         SEQ_W           = 16,
   parameter int         BRAM_ADDR_WIDTH = 12,
   parameter int         SENDER_OFFSET   = 8,
   parameter int         SEQ_OFFSET      = 16,
   parameter int         DATA_OFFSET     = 64,
   parameter logic [7:0] MSG_PUB         = 8'h01,
   parameter logic [7:0] MSG_ACK         = 8'h02
) (
   input  logic                      i_clk,
   input  logic                      i_ap_rst_n,
   input  logic                      i_sequence_numbers_initialized,
   input  logic [NODE_ID_WIDTH-1:0]  i_node_id,
   rpn_lan_rx_pub_acceptor_if.master bus,
`ifdef RPN_LAN_RX_DROP_STATS_EN
   output logic [31:0]               o_dup_count,
   output logic [31:0]               o_drop_count,
`endif
   output logic [2:0]                dbg_state_o
);

   localparam int KEEP_W = AXIS_DATA_WIDTH / 8;

   typedef enum logic [2:0] {
      S_INIT     = 3'd0,
      S_IDLE     = 3'd1,
      S_READ_SEQ = 3'd2,
      S_CLASSIFY = 3'd3,
      S_DELIVER  = 3'd4,
      S_SEND_ACK = 3'd5
   } state_t;

   state_t                     state_q;
   logic                       lan_tready_q;
   logic                       app_tvalid_q;
   logic                       ack_tvalid_q;
   logic [AXIS_DATA_WIDTH-1:0] tdata_q;
   logic [KEEP_W-1:0]          tkeep_q;
   logic [NODE_ID_WIDTH-1:0]   tid_q;
   logic [NODE_ID_WIDTH-1:0]   tdest_q;
   logic [SEQ_W-1:0]           last_q;
   logic [AXIS_DATA_WIDTH-1:0] ack_tdata_q;

   logic [NODE_ID_WIDTH-1:0]   sender_q;
   logic [SEQ_W-1:0]           seq_q;
   logic [NODE_ID_WIDTH-1:0]   in_sender;
   logic                       in_is_pub;
   logic                       lan_accept;
   logic                       app_fire;
   logic                       ack_fire;
   logic [SEQ_W-1:0]           seq_diff;
   logic                       is_new;
   logic                       is_behind;
   logic [AXIS_DATA_WIDTH-1:0] ack_word;

   // Entry n of the sequence table lives at byte address n<<2.
   function automatic logic [BRAM_ADDR_WIDTH-1:0] entry_addr(input logic [NODE_ID_WIDTH-1:0] id);
      return BRAM_ADDR_WIDTH'({id, 2'b00});
   endfunction

   assign sender_q   = tdata_q[SENDER_OFFSET +: NODE_ID_WIDTH];
   assign seq_q      = tdata_q[SEQ_OFFSET +: SEQ_W];
   assign in_sender  = bus.from_nb_LAN_tdata[SENDER_OFFSET +: NODE_ID_WIDTH];
   assign in_is_pub  = bus.from_nb_LAN_tuser[0] && (bus.from_nb_LAN_tdata[7:0] == MSG_PUB);
   assign lan_accept = (state_q == S_IDLE) && lan_tready_q && bus.from_nb_LAN_tvalid;
   assign app_fire   = (state_q == S_DELIVER) && app_tvalid_q && bus.to_app_tready;
   assign ack_fire   = (state_q == S_SEND_ACK) && ack_tvalid_q && bus.to_nb_ack_tready;

   // Modular distance: 1 is the next packet, 0 or "negative" is a retransmit.
   assign seq_diff  = seq_q - last_q;
   assign is_new    = (seq_diff == SEQ_W'(1));
   assign is_behind = (seq_diff == '0) || seq_diff[SEQ_W-1];

   // ACK packet: type, own node id, echoed sequence number, everything else zero.
   always_comb begin
      ack_word                                   = '0;
      ack_word[7:0]                              = MSG_ACK;
      ack_word[SENDER_OFFSET +: NODE_ID_WIDTH]   = i_node_id;
      ack_word[SEQ_OFFSET +: SEQ_W]              = seq_q;
   end

   // BRAM port: the read is issued on the accepting IDLE cycle so DOUT is valid
   // during READ_SEQ; the write happens only on the payload handshake cycle.
   always_comb begin
      bus.seq_BRAM_EN   = (lan_accept && in_is_pub) || app_fire;
      bus.seq_BRAM_WEN  = app_fire ? 4'hF : 4'h0;
      bus.seq_BRAM_ADDR = app_fire ? entry_addr(sender_q) : entry_addr(in_sender);
      bus.seq_BRAM_DIN  = seq_q;
   end

   assign bus.seq_BRAM_CLK = i_clk;
   assign bus.seq_BRAM_RST = ~i_ap_rst_n;

   assign bus.from_nb_LAN_tready = lan_tready_q;
   assign bus.to_app_tvalid      = app_tvalid_q;
   assign bus.to_app_tdata       = AXIS_DATA_WIDTH'(tdata_q[AXIS_DATA_WIDTH-1:DATA_OFFSET]);
   assign bus.to_app_tkeep       = tkeep_q;
   assign bus.to_app_tid         = tid_q;
   assign bus.to_app_tdest       = tdest_q;
   assign bus.to_app_tlast       = 1'b1;
   assign bus.to_nb_ack_tvalid   = ack_tvalid_q;
   assign bus.to_nb_ack_tdata    = ack_tdata_q;
   assign bus.to_nb_ack_tdest    = sender_q;
   assign bus.to_nb_ack_tlast    = 1'b1;
   assign dbg_state_o            = state_q;

   // Packet FSM with registered handshake outputs.
   always_ff @(posedge i_clk or negedge i_ap_rst_n) begin
      if (!i_ap_rst_n) begin
         state_q      <= S_INIT;
         lan_tready_q <= 1'b0;
         app_tvalid_q <= 1'b0;
         ack_tvalid_q <= 1'b0;
         tdata_q      <= '0;
         tkeep_q      <= '0;
         tid_q        <= '0;
         tdest_q      <= '0;
         last_q       <= '0;
         ack_tdata_q  <= '0;
      end else begin
         case (state_q)
            S_INIT: begin
               if (i_sequence_numbers_initialized) begin
                  state_q      <= S_IDLE;
                  lan_tready_q <= 1'b1;
               end
            end
            S_IDLE: begin
               if (lan_accept) begin
                  tdata_q <= bus.from_nb_LAN_tdata;
                  tkeep_q <= bus.from_nb_LAN_tkeep;
                  tid_q   <= bus.from_nb_LAN_tid;
                  tdest_q <= bus.from_nb_LAN_tdest;
                  // Non-PUB / data beats are consumed and forgotten.
                  if (in_is_pub) begin
                     lan_tready_q <= 1'b0;
                     state_q      <= S_READ_SEQ;
                  end
               end
            end
            S_READ_SEQ: begin
               last_q  <= bus.seq_BRAM_DOUT;
               state_q <= S_CLASSIFY;
            end
            S_CLASSIFY: begin
               if (is_new) begin
                  app_tvalid_q <= 1'b1;
                  state_q      <= S_DELIVER;
               end else if (is_behind) begin
                  ack_tvalid_q <= 1'b1;
                  ack_tdata_q  <= ack_word;
                  state_q      <= S_SEND_ACK;
               end else begin
                  lan_tready_q <= 1'b1;
                  state_q      <= S_IDLE;
               end
            end
            S_DELIVER: begin
               if (app_fire) begin
                  app_tvalid_q <= 1'b0;
                  ack_tvalid_q <= 1'b1;
                  ack_tdata_q  <= ack_word;
                  state_q      <= S_SEND_ACK;
               end
            end
            S_SEND_ACK: begin
               if (ack_fire) begin
                  ack_tvalid_q <= 1'b0;
                  lan_tready_q <= 1'b1;
                  state_q      <= S_IDLE;
               end
            end
            default: begin
               state_q      <= S_INIT;
               lan_tready_q <= 1'b0;
               app_tvalid_q <= 1'b0;
               ack_tvalid_q <= 1'b0;
            end
         endcase
      end
   end

`ifdef RPN_LAN_RX_DROP_STATS_EN
   logic [31:0] dup_count_q;
   logic [31:0] drop_count_q;
   logic        dup_evt;
   logic        drop_evt;

   assign dup_evt  = (state_q == S_CLASSIFY) && !is_new && is_behind;
   assign drop_evt = ((state_q == S_CLASSIFY) && !is_new && !is_behind) ||
                     (lan_accept && !in_is_pub);

   // Saturating duplicate / drop statistics.
   always_ff @(posedge i_clk or negedge i_ap_rst_n) begin
      if (!i_ap_rst_n) begin
         dup_count_q  <= '0;
         drop_count_q <= '0;
      end else begin
         if (dup_evt && (dup_count_q != 32'hFFFF_FFFF))
            dup_count_q <= dup_count_q + 32'd1;
         if (drop_evt && (drop_count_q != 32'hFFFF_FFFF))
            drop_count_q <= drop_count_q + 32'd1;
      end
   end

   assign o_dup_count  = dup_count_q;
   assign o_drop_count = drop_count_q;
`endif

   // Fields carried on the bus that this block has no use for.
   logic unused_inputs;
   assign unused_inputs = ^{bus.from_nb_LAN_tlast, bus.from_nb_LAN_tuser, tdata_q};

endmodule

// File: tb/tb_rpn_lan_rx_pub_acceptor.sv
// Directed bench for rpn_lan_rx_pub_acceptor: behavioural BRAM, stream
// monitors, one task per scenario. Optional stats checks follow
// RPN_LAN_RX_DROP_STATS_EN.
module tb_rpn_lan_rx_pub_acceptor;
   localparam int AW  = 512;
   localparam int NW  = 8;
   localparam int SW  = 16;
   localparam int BAW = 12;
   localparam int UW  = 8;
   localparam int KW  = AW / 8;

   localparam logic [7:0]    NODE_ID   = 8'h2A;
   localparam logic [KW-1:0] KEEP_PAT  = 64'hFFFF_0000_FFFF_0001;
   localparam logic [NW-1:0] TID_PAT   = 8'h13;
   localparam logic [NW-1:0] TDEST_PAT = 8'h55;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          rst_n;
   logic          init;
   logic [NW-1:0] node_id;
   logic [2:0]    dbg_state;
`ifdef RPN_LAN_RX_DROP_STATS_EN
   logic [31:0]   dup_count;
   logic [31:0]   drop_count;
`endif

   rpn_lan_rx_pub_acceptor_if #(
      .AXIS_DATA_WIDTH(AW), .NODE_ID_WIDTH(NW), .SEQ_W(SW),
      .BRAM_ADDR_WIDTH(BAW), .USER_WIDTH(UW)
   ) bus ();

   rpn_lan_rx_pub_acceptor dut (
      .i_clk                          (clk),
      .i_ap_rst_n                     (rst_n),
      .i_sequence_numbers_initialized (init),
      .i_node_id                      (node_id),
      .bus                            (bus),
`ifdef RPN_LAN_RX_DROP_STATS_EN
      .o_dup_count                    (dup_count),
      .o_drop_count                   (drop_count),
`endif
      .dbg_state_o                    (dbg_state)
   );

   int checks = 0;
   int errors = 0;
   int cyc    = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // ---------------- behavioural BRAM ----------------
   logic [SW-1:0] mem [0:1023];
   logic          pre_we = 1'b0;
   logic [9:0]    pre_idx = '0;
   logic [SW-1:0] pre_val = '0;
   int            wr_cnt = 0;
   int            rd_cnt = 0;
   int            wr_cyc = 0;
   logic [BAW-1:0] wr_addr = '0;
   logic [SW-1:0]  wr_data = '0;

   always @(posedge clk) begin
      if (pre_we) mem[pre_idx] <= pre_val;
      if (bus.seq_BRAM_EN) begin
         bus.seq_BRAM_DOUT <= mem[bus.seq_BRAM_ADDR[11:2]];
         if (|bus.seq_BRAM_WEN) begin
            mem[bus.seq_BRAM_ADDR[11:2]] <= bus.seq_BRAM_DIN;
            wr_cnt++;
            wr_addr = bus.seq_BRAM_ADDR;
            wr_data = bus.seq_BRAM_DIN;
            wr_cyc  = cyc;
         end else begin
            rd_cnt++;
         end
      end
   end

   // ---------------- stream monitors ----------------
   int            acc_cnt = 0, acc_cyc = 0;
   int            app_cnt = 0, app_cyc = 0;
   int            ack_cnt = 0, ack_cyc = 0;
   logic [AW-1:0] app_data, ack_data;
   logic [KW-1:0] app_keep;
   logic [NW-1:0] app_tid, app_tdest, ack_tdest;
   logic          app_tlast, ack_tlast;

   always @(posedge clk) begin
      if (bus.from_nb_LAN_tvalid && bus.from_nb_LAN_tready) begin
         acc_cnt++;
         acc_cyc = cyc;
      end
      if (bus.to_app_tvalid && bus.to_app_tready) begin
         app_cnt++;
         app_cyc   = cyc;
         app_data  = bus.to_app_tdata;
         app_keep  = bus.to_app_tkeep;
         app_tid   = bus.to_app_tid;
         app_tdest = bus.to_app_tdest;
         app_tlast = bus.to_app_tlast;
      end
      if (bus.to_nb_ack_tvalid && bus.to_nb_ack_tready) begin
         ack_cnt++;
         ack_cyc   = cyc;
         ack_data  = bus.to_nb_ack_tdata;
         ack_tdest = bus.to_nb_ack_tdest;
         ack_tlast = bus.to_nb_ack_tlast;
      end
   end

   // ---------------- expected-value helpers ----------------
   function automatic logic [AW-1:0] exp_ack(input logic [SW-1:0] seq);
      logic [AW-1:0] w;
      w        = '0;
      w[7:0]   = 8'h02;
      w[15:8]  = NODE_ID;
      w[31:16] = seq;
      return w;
   endfunction

   function automatic logic [AW-1:0] exp_payload(input logic [63:0] p);
      logic [AW-1:0] w;
      w       = '0;
      w[63:0] = p;
      return w;
   endfunction

   // ---------------- driver tasks ----------------
   task automatic bram_set(input logic [9:0] idx, input logic [SW-1:0] val);
      @(negedge clk);
      pre_we  = 1'b1;
      pre_idx = idx;
      pre_val = val;
      @(negedge clk);
      pre_we  = 1'b0;
   endtask

   task automatic send_beat(input logic [7:0] typ, input logic [7:0] sender,
                            input logic [15:0] seq, input logic [63:0] payload,
                            input logic ctrl, output bit timed_out);
      logic [AW-1:0] d;
      int n;
      n = 0;
      timed_out = 1'b0;
      @(negedge clk);
      while (!bus.from_nb_LAN_tready && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (!bus.from_nb_LAN_tready) begin
         timed_out = 1'b1;
         return;
      end
      d          = '0;
      d[7:0]     = typ;
      d[15:8]    = sender;
      d[31:16]   = seq;
      d[127:64]  = payload;
      bus.from_nb_LAN_tdata  = d;
      bus.from_nb_LAN_tkeep  = KEEP_PAT;
      bus.from_nb_LAN_tid    = TID_PAT;
      bus.from_nb_LAN_tdest  = TDEST_PAT;
      bus.from_nb_LAN_tuser  = {7'd0, ctrl};
      bus.from_nb_LAN_tlast  = 1'b1;
      bus.from_nb_LAN_tvalid = 1'b1;
      @(posedge clk);
      #1;
      bus.from_nb_LAN_tvalid = 1'b0;
      bus.from_nb_LAN_tuser  = '0;
   endtask

   task automatic wait_ack(input int base, output bit timed_out);
      int n;
      n = 0;
      while (ack_cnt <= base && n < 50) begin
         @(negedge clk);
         n++;
      end
      timed_out = (ack_cnt <= base);
   endtask

   task automatic wait_app_valid(output bit timed_out);
      int n;
      n = 0;
      @(negedge clk);
      while (!bus.to_app_tvalid && n < 50) begin
         @(negedge clk);
         n++;
      end
      timed_out = !bus.to_app_tvalid;
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      rst_n = 1'b0;
      init  = 1'b0;
      repeat (3) @(negedge clk);
      checks++; if (dbg_state !== 3'd0) begin errors++; $display("FAIL reset_state got %0d want 0", dbg_state); end
      checks++; if (bus.from_nb_LAN_tready !== 1'b0) begin errors++; $display("FAIL reset_lan_tready got %b want 0", bus.from_nb_LAN_tready); end
      checks++; if (bus.to_app_tvalid !== 1'b0 || bus.to_nb_ack_tvalid !== 1'b0) begin errors++; $display("FAIL reset_valids got app=%b ack=%b want 0/0", bus.to_app_tvalid, bus.to_nb_ack_tvalid); end
      checks++; if (bus.seq_BRAM_EN !== 1'b0 || bus.seq_BRAM_WEN !== 4'h0) begin errors++; $display("FAIL reset_bram got en=%b wen=%h want 0/0", bus.seq_BRAM_EN, bus.seq_BRAM_WEN); end
      checks++; if (bus.to_app_tdata !== '0 || bus.to_nb_ack_tdata !== '0) begin errors++; $display("FAIL reset_data got nonzero app/ack tdata want 0"); end
      checks++; if (bus.seq_BRAM_RST !== 1'b1) begin errors++; $display("FAIL reset_bram_rst got %b want 1", bus.seq_BRAM_RST); end
      @(negedge clk);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      checks++; if (dbg_state !== 3'd0 || bus.from_nb_LAN_tready !== 1'b0) begin errors++; $display("FAIL hold_init got state=%0d tready=%b want 0/0", dbg_state, bus.from_nb_LAN_tready); end
      init = 1'b1;
      repeat (2) @(negedge clk);
      checks++; if (dbg_state !== 3'd1 || bus.from_nb_LAN_tready !== 1'b1) begin errors++; $display("FAIL init_to_idle got state=%0d tready=%b want 1/1", dbg_state, bus.from_nb_LAN_tready); end
   endtask

   task automatic test_new_pub();
      int a0, w0, k0, r0;
      bit to;
      bram_set(10'd3, 16'd5);
      a0 = app_cnt; w0 = wr_cnt; k0 = ack_cnt; r0 = rd_cnt;
      send_beat(8'h01, 8'd3, 16'd6, 64'hABCD, 1'b1, to);
      checks++; if (to) begin errors++; $display("FAIL new_accept got timeout want tready"); end
      wait_ack(k0, to);
      checks++; if (to) begin errors++; $display("FAIL new_ack_wait got timeout want ack"); end
      checks++; if (app_cnt != a0 + 1) begin errors++; $display("FAIL new_app_count got %0d want %0d", app_cnt - a0, 1); end
      checks++; if (app_data !== exp_payload(64'hABCD)) begin errors++; $display("FAIL new_app_data got %h want abcd", app_data[63:0]); end
      checks++; if (app_keep !== KEEP_PAT || app_tid !== TID_PAT || app_tdest !== TDEST_PAT || app_tlast !== 1'b1) begin errors++; $display("FAIL new_app_side got keep=%h tid=%h tdest=%h tlast=%b", app_keep, app_tid, app_tdest, app_tlast); end
      checks++; if (rd_cnt != r0 + 1) begin errors++; $display("FAIL new_bram_reads got %0d want 1", rd_cnt - r0); end
      checks++; if (wr_cnt != w0 + 1 || wr_addr !== 12'h00C || wr_data !== 16'd6) begin errors++; $display("FAIL new_bram_write got n=%0d addr=%h data=%h want 1/00c/0006", wr_cnt - w0, wr_addr, wr_data); end
      checks++; if (mem[3] !== 16'd6) begin errors++; $display("FAIL new_bram_entry got %h want 0006", mem[3]); end
      checks++; if (wr_cyc != app_cyc) begin errors++; $display("FAIL new_write_timing got cyc %0d want %0d", wr_cyc, app_cyc); end
      checks++; if (ack_cnt != k0 + 1 || ack_data !== exp_ack(16'd6) || ack_tdest !== 8'd3 || ack_tlast !== 1'b1) begin errors++; $display("FAIL new_ack got n=%0d data=%h tdest=%h want 1/ack seq 6/03", ack_cnt - k0, ack_data[31:0], ack_tdest); end
      checks++; if (!(ack_cyc > app_cyc)) begin errors++; $display("FAIL new_order got ack cyc %0d app cyc %0d want ack later", ack_cyc, app_cyc); end
      checks++; if (ack_cyc - acc_cyc != 4) begin errors++; $display("FAIL new_turnaround got %0d want 4", ack_cyc - acc_cyc); end
   endtask

   task automatic test_duplicate();
      int a0, w0, k0;
      bit to;
      a0 = app_cnt; w0 = wr_cnt; k0 = ack_cnt;
      send_beat(8'h01, 8'd3, 16'd6, 64'hABCD, 1'b1, to);
      checks++; if (to) begin errors++; $display("FAIL dup_accept got timeout want tready"); end
      wait_ack(k0, to);
      checks++; if (to) begin errors++; $display("FAIL dup_ack_wait got timeout want ack"); end
      checks++; if (app_cnt != a0 || wr_cnt != w0) begin errors++; $display("FAIL dup_no_deliver got app=%0d wr=%0d want 0/0", app_cnt - a0, wr_cnt - w0); end
      checks++; if (ack_data !== exp_ack(16'd6) || ack_tdest !== 8'd3) begin errors++; $display("FAIL dup_ack got data=%h tdest=%h want seq 6/03", ack_data[31:0], ack_tdest); end
      checks++; if (ack_cyc - acc_cyc != 3) begin errors++; $display("FAIL dup_turnaround got %0d want 3", ack_cyc - acc_cyc); end
`ifdef RPN_LAN_RX_DROP_STATS_EN
      checks++; if (dup_count !== 32'd1 || drop_count !== 32'd0) begin errors++; $display("FAIL dup_stats got dup=%0d drop=%0d want 1/0", dup_count, drop_count); end
`endif
   endtask

   task automatic test_ahead();
      int a0, w0, k0;
      bit to;
      bram_set(10'd3, 16'd5);
      a0 = app_cnt; w0 = wr_cnt; k0 = ack_cnt;
      send_beat(8'h01, 8'd3, 16'd9, 64'h9999, 1'b1, to);
      checks++; if (to) begin errors++; $display("FAIL ahead_accept got timeout want tready"); end
      @(negedge clk);
      checks++; if (dbg_state !== 3'd2) begin errors++; $display("FAIL ahead_read_state got %0d want 2", dbg_state); end
      @(negedge clk);
      checks++; if (dbg_state !== 3'd3) begin errors++; $display("FAIL ahead_classify_state got %0d want 3", dbg_state); end
      @(negedge clk);
      checks++; if (dbg_state !== 3'd1 || bus.from_nb_LAN_tready !== 1'b1) begin errors++; $display("FAIL ahead_back_idle got state=%0d tready=%b want 1/1", dbg_state, bus.from_nb_LAN_tready); end
      repeat (8) @(negedge clk);
      checks++; if (app_cnt != a0 || wr_cnt != w0 || ack_cnt != k0) begin errors++; $display("FAIL ahead_silent got app=%0d wr=%0d ack=%0d want 0/0/0", app_cnt - a0, wr_cnt - w0, ack_cnt - k0); end
      checks++; if (mem[3] !== 16'd5) begin errors++; $display("FAIL ahead_entry got %h want 0005", mem[3]); end
`ifdef RPN_LAN_RX_DROP_STATS_EN
      checks++; if (dup_count !== 32'd1 || drop_count !== 32'd1) begin errors++; $display("FAIL ahead_stats got dup=%0d drop=%0d want 1/1", dup_count, drop_count); end
`endif
   endtask

   task automatic test_non_pub();
      int a0, k0, r0;
      bit to;
      a0 = app_cnt; k0 = ack_cnt; r0 = rd_cnt;
      send_beat(8'h03, 8'd3, 16'd6, 64'h1, 1'b1, to);
      checks++; if (to) begin errors++; $display("FAIL nonpub_type_accept got timeout want tready"); end
      @(negedge clk);
      checks++; if (dbg_state !== 3'd1 || bus.from_nb_LAN_tready !== 1'b1) begin errors++; $display("FAIL nonpub_type_idle got state=%0d tready=%b want 1/1", dbg_state, bus.from_nb_LAN_tready); end
      send_beat(8'h01, 8'd3, 16'd6, 64'h2, 1'b0, to);
      checks++; if (to) begin errors++; $display("FAIL nonpub_data_accept got timeout want tready"); end
      @(negedge clk);
      checks++; if (dbg_state !== 3'd1) begin errors++; $display("FAIL nonpub_data_idle got state=%0d want 1", dbg_state); end
      repeat (6) @(negedge clk);
      checks++; if (rd_cnt != r0 || app_cnt != a0 || ack_cnt != k0) begin errors++; $display("FAIL nonpub_silent got rd=%0d app=%0d ack=%0d want 0/0/0", rd_cnt - r0, app_cnt - a0, ack_cnt - k0); end
`ifdef RPN_LAN_RX_DROP_STATS_EN
      checks++; if (dup_count !== 32'd1 || drop_count !== 32'd3) begin errors++; $display("FAIL nonpub_stats got dup=%0d drop=%0d want 1/3", dup_count, drop_count); end
`endif
   endtask

   task automatic test_wrap();
      int a0, k0;
      bit to;
      bram_set(10'd1, 16'hFFFF);
      a0 = app_cnt; k0 = ack_cnt;
      send_beat(8'h01, 8'd1, 16'h0000, 64'h1122_3344_5566_7788, 1'b1, to);
      checks++; if (to) begin errors++; $display("FAIL wrap_accept got timeout want tready"); end
      wait_ack(k0, to);
      checks++; if (to) begin errors++; $display("FAIL wrap_ack_wait got timeout want ack"); end
      checks++; if (app_cnt != a0 + 1 || app_data !== exp_payload(64'h1122_3344_5566_7788)) begin errors++; $display("FAIL wrap_deliver got n=%0d data=%h", app_cnt - a0, app_data[63:0]); end
      checks++; if (mem[1] !== 16'h0000 || wr_addr !== 12'h004) begin errors++; $display("FAIL wrap_write got entry=%h addr=%h want 0000/004", mem[1], wr_addr); end
      checks++; if (ack_data !== exp_ack(16'h0000) || ack_tdest !== 8'd1) begin errors++; $display("FAIL wrap_ack got data=%h tdest=%h want seq 0/01", ack_data[31:0], ack_tdest); end
   endtask

   task automatic test_backpressure();
      int a0, w0, k0;
      bit to;
      bram_set(10'd5, 16'h0010);
      bus.to_app_tready    = 1'b0;
      bus.to_nb_ack_tready = 1'b0;
      a0 = app_cnt; w0 = wr_cnt; k0 = ack_cnt;
      send_beat(8'h01, 8'd5, 16'h0011, 64'hCAFE, 1'b1, to);
      checks++; if (to) begin errors++; $display("FAIL bp_accept got timeout want tready"); end
      wait_app_valid(to);
      checks++; if (to) begin errors++; $display("FAIL bp_app_valid got timeout want valid"); end
      for (int i = 0; i < 10; i++) begin
         checks++;
         if (bus.to_app_tvalid !== 1'b1 || bus.to_app_tdata !== exp_payload(64'hCAFE) ||
             bus.from_nb_LAN_tready !== 1'b0 || bus.to_nb_ack_tvalid !== 1'b0 || wr_cnt != w0) begin
            errors++;
            $display("FAIL bp_app_hold cycle %0d got valid=%b data=%h tready=%b ackv=%b wr=%0d", i,
                     bus.to_app_tvalid, bus.to_app_tdata[63:0], bus.from_nb_LAN_tready, bus.to_nb_ack_tvalid, wr_cnt - w0);
         end
         @(negedge clk);
      end
      bus.to_app_tready = 1'b1;
      @(posedge clk);
      #1;
      bus.to_app_tready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         checks++;
         if (bus.to_nb_ack_tvalid !== 1'b1 || bus.to_nb_ack_tdata !== exp_ack(16'h0011) ||
             bus.to_nb_ack_tdest !== 8'd5 || bus.from_nb_LAN_tready !== 1'b0 || bus.to_app_tvalid !== 1'b0) begin
            errors++;
            $display("FAIL bp_ack_hold cycle %0d got ackv=%b data=%h tdest=%h tready=%b appv=%b", i,
                     bus.to_nb_ack_tvalid, bus.to_nb_ack_tdata[31:0], bus.to_nb_ack_tdest, bus.from_nb_LAN_tready, bus.to_app_tvalid);
         end
      end
      bus.to_nb_ack_tready = 1'b1;
      wait_ack(k0, to);
      checks++; if (to) begin errors++; $display("FAIL bp_ack_wait got timeout want ack"); end
      checks++; if (app_cnt != a0 + 1 || wr_cnt != w0 + 1 || ack_cnt != k0 + 1) begin errors++; $display("FAIL bp_single got app=%0d wr=%0d ack=%0d want 1/1/1", app_cnt - a0, wr_cnt - w0, ack_cnt - k0); end
      checks++; if (mem[5] !== 16'h0011) begin errors++; $display("FAIL bp_entry got %h want 0011", mem[5]); end
      bus.to_app_tready = 1'b1;
   endtask

   task automatic test_reset_mid();
      int w0;
      bit to;
      bram_set(10'd7, 16'd2);
      bus.to_app_tready = 1'b0;
      w0 = wr_cnt;
      send_beat(8'h01, 8'd7, 16'd3, 64'h77, 1'b1, to);
      checks++; if (to) begin errors++; $display("FAIL rstmid_accept got timeout want tready"); end
      wait_app_valid(to);
      checks++; if (to) begin errors++; $display("FAIL rstmid_app_valid got timeout want valid"); end
      rst_n = 1'b0;
      #1;
      checks++; if (bus.to_app_tvalid !== 1'b0 || bus.to_nb_ack_tvalid !== 1'b0 || bus.from_nb_LAN_tready !== 1'b0) begin errors++; $display("FAIL rstmid_outputs got appv=%b ackv=%b tready=%b want 0/0/0", bus.to_app_tvalid, bus.to_nb_ack_tvalid, bus.from_nb_LAN_tready); end
      checks++; if (dbg_state !== 3'd0 || bus.seq_BRAM_EN !== 1'b0) begin errors++; $display("FAIL rstmid_state got state=%0d en=%b want 0/0", dbg_state, bus.seq_BRAM_EN); end
`ifdef RPN_LAN_RX_DROP_STATS_EN
      checks++; if (dup_count !== 32'd0 || drop_count !== 32'd0) begin errors++; $display("FAIL rstmid_stats got dup=%0d drop=%0d want 0/0", dup_count, drop_count); end
`endif
      bus.to_app_tready = 1'b1;
      @(negedge clk);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      checks++; if (wr_cnt != w0 || mem[7] !== 16'd2) begin errors++; $display("FAIL rstmid_bram got wr=%0d entry=%h want 0/0002", wr_cnt - w0, mem[7]); end
      checks++; if (dbg_state !== 3'd1) begin errors++; $display("FAIL rstmid_recover got state=%0d want 1", dbg_state); end
   endtask

   // ---------------- watchdog ----------------
   initial begin
      #300000;
      $display("FAIL watchdog got no finish want finish");
      $fatal(1, "watchdog expired");
   end

   // ---------------- main sequence ----------------
   initial begin
      node_id                = NODE_ID;
      rst_n                  = 1'b0;
      init                   = 1'b0;
      bus.from_nb_LAN_tvalid = 1'b0;
      bus.from_nb_LAN_tdata  = '0;
      bus.from_nb_LAN_tkeep  = '0;
      bus.from_nb_LAN_tid    = '0;
      bus.from_nb_LAN_tdest  = '0;
      bus.from_nb_LAN_tuser  = '0;
      bus.from_nb_LAN_tlast  = 1'b0;
      bus.to_app_tready      = 1'b1;
      bus.to_nb_ack_tready   = 1'b1;

      test_reset();
      test_new_pub();
      test_duplicate();
      test_ahead();
      test_non_pub();
      test_wrap();
      test_backpressure();
      test_reset_mid();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
